// File: rtl/predictor_ctrl_if.sv
// -----------------------------------------------------------------------------
// predictor_ctrl_if
// Bundles the fetch-query, prediction-result and commit-update signals of the
// branch predictor controller.
//   master : fetch / ROB side (drives queries, updates, flush)
//   slave  : predictor_ctrl side (drives readies and prediction result)
// Optional macro PREDICTOR_STAT_EN adds upd_pred_taken, stat_branches and
// stat_miss.
// -----------------------------------------------------------------------------
interface predictor_ctrl_if;
    logic        query_valid;
    logic        query_ready;
    logic [31:0] query_pc;
    logic [31:0] query_inst;
    logic        pred_valid;
    logic        pred_jump;
    logic [31:0] pred_target_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush;
`ifdef PREDICTOR_STAT_EN
    logic        upd_pred_taken;
    logic [31:0] stat_branches;
    logic [31:0] stat_miss;

    modport master (
        output query_valid, query_pc, query_inst, upd_valid, upd_pc, upd_taken,
               flush, upd_pred_taken,
        input  query_ready, pred_valid, pred_jump, pred_target_pc, upd_ready,
               stat_branches, stat_miss
    );
    modport slave (
        input  query_valid, query_pc, query_inst, upd_valid, upd_pc, upd_taken,
               flush, upd_pred_taken,
        output query_ready, pred_valid, pred_jump, pred_target_pc, upd_ready,
               stat_branches, stat_miss
    );
`else
    modport master (
        output query_valid, query_pc, query_inst, upd_valid, upd_pc, upd_taken,
               flush,
        input  query_ready, pred_valid, pred_jump, pred_target_pc, upd_ready
    );
    modport slave (
        input  query_valid, query_pc, query_inst, upd_valid, upd_pc, upd_taken,
               flush,
        output query_ready, pred_valid, pred_jump, pred_target_pc, upd_ready
    );
`endif
endinterface

// File: rtl/predictor_ctrl.sv
// -----------------------------------------------------------------------------
// predictor_ctrl
// Owns the branch history table (2^IDX_W two-bit saturating counters behind a
// single access port). After reset the table is swept to weakly-not-taken,
// then each cycle the port serves either an accepted fetch query (priority)
// or one drain of the commit-side update FIFO.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - predictor_ctrl_if.slave: query handshake, registered prediction
//          result, update handshake, flush
// Optional macro PREDICTOR_STAT_EN: counts pushed updates (stat_branches) and
// pushed updates whose predicted direction was wrong (stat_miss).
// -----------------------------------------------------------------------------
module predictor_ctrl #(
    parameter int IDX_W  = 6,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    predictor_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    state_t           state_r;
    logic [IDX_W-1:0] init_ptr_r;
    logic [1:0]       bht_r      [DEPTH];
    logic [IDX_W-1:0] fifo_idx_r [QDEPTH];
    logic             fifo_tkn_r [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pred_valid_r;
    logic             pred_jump_r;
    logic [31:0]      pred_target_r;

    logic             full_s;
    logic             empty_s;
    logic             query_ready_s;
    logic             upd_ready_s;
    logic             accept_s;
    logic             drain_s;
    logic             push_s;
    logic [IDX_W-1:0] query_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             head_tkn_s;
    logic [6:0]       opcode_s;
    logic [31:0]      jimm_s;
    logic [31:0]      bimm_s;
    logic             pred_jump_s;
    logic [31:0]      pred_target_s;
    logic             unused_upd_pc_bits_s;

    assign full_s        = (count_r == FULL_CNT);
    assign empty_s       = (count_r == {CNT_W{1'b0}});
    assign query_ready_s = (state_r == ST_RUN) && !full_s;
    assign upd_ready_s   = !full_s;
    assign accept_s      = bus.query_valid && query_ready_s;
    // The table port goes to the query first; a full FIFO blocks queries,
    // so a drain is guaranteed whenever the FIFO is full in RUN.
    assign drain_s       = (state_r == ST_RUN) && !empty_s && !accept_s;
    assign push_s        = bus.upd_valid && upd_ready_s;
    assign query_idx_s   = bus.query_pc[IDX_W+1:2];
    assign upd_idx_s     = bus.upd_pc[IDX_W+1:2];
    assign head_idx_s    = fifo_idx_r[rd_ptr_r];
    assign head_tkn_s    = fifo_tkn_r[rd_ptr_r];
    assign opcode_s      = bus.query_inst[6:0];
    assign jimm_s        = {{11{bus.query_inst[31]}}, bus.query_inst[31], bus.query_inst[19:12],
                            bus.query_inst[20], bus.query_inst[30:21], 1'b0};
    assign bimm_s        = {{19{bus.query_inst[31]}}, bus.query_inst[31], bus.query_inst[7],
                            bus.query_inst[30:25], bus.query_inst[11:8], 1'b0};
    assign unused_upd_pc_bits_s = ^{bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};

    // Prediction decode of the presented instruction; table read has no FIFO bypass.
    always_comb begin
        pred_jump_s   = 1'b0;
        pred_target_s = bus.query_pc + 32'd4;
        case (opcode_s)
            OPC_JAL: begin
                pred_jump_s   = 1'b1;
                pred_target_s = bus.query_pc + jimm_s;
            end
            OPC_BRANCH: begin
                pred_jump_s = bht_r[query_idx_s][1];
                if (pred_jump_s) begin
                    pred_target_s = bus.query_pc + bimm_s;
                end else begin
                    pred_target_s = bus.query_pc + 32'd4;
                end
            end
            default: begin
                pred_jump_s   = 1'b0;
                pred_target_s = bus.query_pc + 32'd4;
            end
        endcase
    end

    // Control FSM: sweep sequencing, FIFO pointers/count and registered prediction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_INIT;
            init_ptr_r    <= {IDX_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            pred_valid_r  <= 1'b0;
            pred_jump_r   <= 1'b0;
            pred_target_r <= 32'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_ptr_r <= init_ptr_r + IDX_W'(1);
                    if (init_ptr_r == LAST_IDX) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_INIT;
            endcase

            // A flush in the accept cycle kills the result; later flushes do not.
            pred_valid_r <= accept_s && !bus.flush;
            if (accept_s) begin
                pred_jump_r   <= pred_jump_s;
                pred_target_r <= pred_target_s;
            end

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (drain_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, drain_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Table and FIFO storage: sweep write, or drain read-modify-write; FIFO push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_INIT) begin
                bht_r[init_ptr_r] <= 2'b01;
            end else if (drain_s) begin
                bht_r[head_idx_s] <= sat_update(bht_r[head_idx_s], head_tkn_s);
            end
            if (push_s) begin
                fifo_idx_r[wr_ptr_r] <= upd_idx_s;
                fifo_tkn_r[wr_ptr_r] <= bus.upd_taken;
            end
        end
    end

    assign bus.query_ready    = query_ready_s;
    assign bus.upd_ready      = upd_ready_s;
    assign bus.pred_valid     = pred_valid_r;
    assign bus.pred_jump      = pred_jump_r;
    assign bus.pred_target_pc = pred_target_r;

`ifdef PREDICTOR_STAT_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_miss_r;

    // Statistics counters, stepped on each accepted update push.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_r <= 32'd0;
            stat_miss_r     <= 32'd0;
        end else if (push_s) begin
            stat_branches_r <= stat_branches_r + 32'd1;
            if (bus.upd_pred_taken != bus.upd_taken) begin
                stat_miss_r <= stat_miss_r + 32'd1;
            end
        end
    end

    assign bus.stat_branches = stat_branches_r;
    assign bus.stat_miss     = stat_miss_r;
`endif
endmodule

// File: tb/tb_predictor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_predictor_ctrl
// Directed stimulus against predictor_ctrl with a queue-based behavioural
// model checked every cycle, plus literal expectations for key scenarios.
// -----------------------------------------------------------------------------
module tb_predictor_ctrl;
    localparam int IDX_W  = 6;
    localparam int QDEPTH = 4;
    localparam int TBL    = 1 << IDX_W;

    logic clk;
    logic rst;
    predictor_ctrl_if bus ();

    predictor_ctrl #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {int idx; bit taken;} upd_t;
    int         m_bht [TBL];
    upd_t       m_q [$];
    int         m_init_left;
    bit         m_live = 1'b0;
    bit         e_pv, e_pj;
    logic [31:0] e_pt;
    int         e_sb, e_sm;

    function automatic void predict(input logic [31:0] pc, input logic [31:0] inst,
                                    input int ctr, output bit j, output logic [31:0] t);
        logic [31:0] jimm, bimm;
        jimm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        bimm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        if (inst[6:0] == 7'b1101111) begin
            j = 1'b1;
            t = pc + jimm;
        end else if (inst[6:0] == 7'b1100011) begin
            j = (ctr >= 2);
            t = j ? pc + bimm : pc + 32'd4;
        end else begin
            j = 1'b0;
            t = pc + 32'd4;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_live      = 1'b1;
            m_init_left = TBL;
            m_q.delete();
            for (int i = 0; i < TBL; i++) m_bht[i] = 1;
            e_pv = 1'b0; e_pj = 1'b0; e_pt = 32'd0;
            e_sb = 0; e_sm = 0;
        end else if (m_live) begin
            bit qr, ur, acc;
            qr = (m_init_left == 0) && (m_q.size() < QDEPTH);
            ur = (m_q.size() < QDEPTH);
            cmp("m_query_ready", {31'd0, bus.query_ready}, {31'd0, qr});
            cmp("m_upd_ready", {31'd0, bus.upd_ready}, {31'd0, ur});
            cmp("m_pred_valid", {31'd0, bus.pred_valid}, {31'd0, e_pv});
            if (e_pv) begin
                cmp("m_pred_jump", {31'd0, bus.pred_jump}, {31'd0, e_pj});
                cmp("m_pred_target", bus.pred_target_pc, e_pt);
            end
`ifdef PREDICTOR_STAT_EN
            cmp("m_stat_branches", bus.stat_branches, e_sb);
            cmp("m_stat_miss", bus.stat_miss, e_sm);
`endif
            // advance to the state after the coming edge
            acc = bus.query_valid && qr;
            if (acc) begin
                predict(bus.query_pc, bus.query_inst,
                        m_bht[(bus.query_pc >> 2) % TBL], e_pj, e_pt);
                e_pv = !bus.flush;
            end else begin
                e_pv = 1'b0;
            end
            if ((m_init_left == 0) && (m_q.size() > 0) && !acc) begin
                upd_t u;
                u = m_q.pop_front();
                if (u.taken) m_bht[u.idx] = (m_bht[u.idx] < 3) ? m_bht[u.idx] + 1 : 3;
                else         m_bht[u.idx] = (m_bht[u.idx] > 0) ? m_bht[u.idx] - 1 : 0;
            end
            if (bus.upd_valid && ur) begin
                upd_t u;
                u.idx   = int'((bus.upd_pc >> 2) % TBL);
                u.taken = bus.upd_taken;
                m_q.push_back(u);
                e_sb++;
`ifdef PREDICTOR_STAT_EN
                if (bus.upd_pred_taken != bus.upd_taken) e_sm++;
`endif
            end
            if (m_init_left > 0) m_init_left--;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_query(input string name, input logic [31:0] pc, input logic [31:0] inst,
                            input bit fl, input bit exp_v, input bit exp_j,
                            input logic [31:0] exp_t);
        bus.query_valid = 1'b1; bus.query_pc = pc; bus.query_inst = inst; bus.flush = fl;
        step();
        bus.query_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        cmp({name, "_valid"}, {31'd0, bus.pred_valid}, {31'd0, exp_v});
        if (exp_v) begin
            cmp({name, "_jump"}, {31'd0, bus.pred_jump}, {31'd0, exp_j});
            cmp({name, "_target"}, bus.pred_target_pc, exp_t);
        end
        step();
    endtask

    task automatic count_sweep(input string name);
        int cnt;
        cnt = 0;
        while (!bus.query_ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        cmp(name, cnt, 32'd64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        logic ur0;
        rst = 1'b1;
        bus.query_valid = 1'b0; bus.query_pc = 32'd0; bus.query_inst = 32'd0;
        bus.upd_valid = 1'b0; bus.upd_pc = 32'd0; bus.upd_taken = 1'b0; bus.flush = 1'b0;
`ifdef PREDICTOR_STAT_EN
        bus.upd_pred_taken = 1'b0;
`endif
        repeat (2) step();

        // sweep length with a query held, then first BRANCH query
        rst = 1'b0;
        bus.query_valid = 1'b1; bus.query_pc = 32'h100; bus.query_inst = 32'h00000063;
        @(negedge clk);
        cmp("rst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        cmp("rst_pred_jump", {31'd0, bus.pred_jump}, 32'd0);
        cmp("rst_pred_target", bus.pred_target_pc, 32'd0);
        cmp("rst_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
        count_sweep("sweep_len");
        step();
        bus.query_valid = 1'b0;
        @(negedge clk);
        cmp("first_br_valid", {31'd0, bus.pred_valid}, 32'd1);
        cmp("first_br_jump", {31'd0, bus.pred_jump}, 32'd0);
        cmp("first_br_target", bus.pred_target_pc, 32'h104);
        step();

        // JAL
        do_query("jal", 32'h200, 32'h0080006F, 1'b0, 1'b1, 1'b1, 32'h208);

        // two taken updates -> counter 3 -> BEQ +16 taken
        bus.upd_pc = 32'h100; bus.upd_taken = 1'b1; bus.upd_valid = 1'b1;
        repeat (2) step();
        bus.upd_valid = 1'b0;
        repeat (3) step();
        do_query("beq_taken", 32'h100, 32'h00000863, 1'b0, 1'b1, 1'b1, 32'h110);

        // four not-taken updates saturate at 0 (wrap would predict taken)
        bus.upd_taken = 1'b0; bus.upd_valid = 1'b1;
        repeat (4) step();
        bus.upd_valid = 1'b0;
        repeat (3) step();
        do_query("beq_sat0", 32'h100, 32'h00000863, 1'b0, 1'b1, 1'b0, 32'h104);

        // fill FIFO while queries hold the port
        bus.query_valid = 1'b1; bus.query_pc = 32'h300; bus.query_inst = 32'h00000013;
        bus.upd_pc = 32'h100; bus.upd_taken = 1'b1; bus.upd_valid = 1'b1;
        repeat (4) step();
        bus.upd_valid = 1'b0;
        nz = 0; ur0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) ur0 = bus.upd_ready;
            if (!bus.query_ready) nz++;
        end
        step();
        bus.query_valid = 1'b0;
        cmp("full_upd_ready", {31'd0, ur0}, 32'd0);
        cmp("full_qr_drop_cycles", nz, 32'd1);
        repeat (5) step();

        // flush in accept cycle
        do_query("flush", 32'h200, 32'h0080006F, 1'b1, 1'b0, 1'b0, 32'd0);

        // reset with three updates queued
        bus.query_valid = 1'b1; bus.query_pc = 32'h300; bus.query_inst = 32'h00000013;
        bus.upd_pc = 32'h100; bus.upd_taken = 1'b1; bus.upd_valid = 1'b1;
        repeat (3) step();
        bus.upd_valid = 1'b0; bus.query_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.query_valid = 1'b1; bus.query_pc = 32'h100; bus.query_inst = 32'h00000863;
        @(negedge clk);
        cmp("rst2_upd_ready", {31'd0, bus.upd_ready}, 32'd1);
        cmp("rst2_query_ready", {31'd0, bus.query_ready}, 32'd0);
        count_sweep("sweep_len2");
        step();
        bus.query_valid = 1'b0;
        @(negedge clk);
        cmp("beq_after_rst_valid", {31'd0, bus.pred_valid}, 32'd1);
        cmp("beq_after_rst_jump", {31'd0, bus.pred_jump}, 32'd0);
        cmp("beq_after_rst_target", bus.pred_target_pc, 32'h104);
        step();

`ifdef PREDICTOR_STAT_EN
        begin
            logic [4:0] tk, pt;
            tk = 5'b01101;
            pt = 5'b00111;
            bus.upd_pc = 32'h140; bus.upd_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                bus.upd_taken = tk[i]; bus.upd_pred_taken = pt[i];
                step();
            end
            bus.upd_valid = 1'b0;
            @(negedge clk);
            cmp("stat_branches", bus.stat_branches, 32'd5);
            cmp("stat_miss", bus.stat_miss, 32'd2);
            step();
        end
`endif

        repeat (6) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/predictor_ctrl.md
Name: predictor_ctrl

Overview:
Owns the branch history table (BHT) for the fetch-stage predictor and sequences all access to it. The table is 2^IDX_W 2-bit saturating counters behind a single access port. Each cycle, the block arbitrates that port between fetch-side prediction queries and commit-side training updates. Updates are buffered in a small FIFO. After reset, the block sweeps the whole table to the weakly-not-taken state before serving queries.

Parameters:
IDX_W, 6, BHT index width; table depth = 2^IDX_W; index = pc[IDX_W+1:2]
QDEPTH, 4, depth of the update FIFO; must be a power of 2, at least 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
query_valid  in  1  fetch presents a query
query_ready  out  1  query accepted this cycle when high together with query_valid
query_pc  in  32  pc of the queried instruction
query_inst  in  32  raw instruction word
pred_valid  out  1  prediction result valid; one cycle after acceptance
pred_jump  out  1  predicted taken
pred_target_pc  out  32  predicted next pc
upd_valid  in  1  ROB commits a conditional branch
upd_ready  out  1  update FIFO can accept
upd_pc  in  32  pc of the committed branch
upd_taken  in  1  actual branch outcome
flush  in  1  pipeline flush from ROB

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset response: state=INIT, init_ptr=0, FIFO empty, pred_valid=0, pred_jump=0, pred_target_pc=0.
- Reset mid-sweep or mid-operation: restarts the sweep and discards all queued updates.
- INIT state:
  - Writes 2'b01 to BHT[init_ptr] each cycle and increments init_ptr.
  - After writing entry 2^IDX_W-1, moves to RUN. The sweep takes exactly 2^IDX_W cycles.
  - query_ready=0 throughout.
  - upd_ready = !full, so updates may queue during INIT.
- RUN state:
  - query_ready = !full (combinational).
  - accept = query_valid && query_ready.
  - Port priority: accepted query > FIFO drain. A drain occurs when !empty && !accept.
  - A full FIFO forces query_ready=0, which guarantees a drain that cycle.
- Query result (registered):
  - pred_valid=1 in the cycle after accept, unless flush is high in the accept cycle.
  - A flush in the result cycle does not retract pred_valid; fetch discards it.
  - When no query is accepted, pred_valid=0 in the next cycle.
- Prediction decode on the accepted instruction:
  - opcode 1101111 (JAL): pred_jump=1, target = pc + JImm.
  - opcode 1100011 (BRANCH): pred_jump = BHT[idx][1], target = pc + BImm if taken, else pc+4.
  - Any other opcode: pred_jump=0, target = pc+4.
- Immediate formats:
  - JImm = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - BImm = sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - All pc adds are mod 2^32.
- No bypass from the FIFO: a query reads the table value before any pending update is applied.
- Update drain:
  - Pops the FIFO head and applies a read-modify-write to BHT[upd_pc idx] in one cycle.
  - taken: counter+1, saturating at 3. not taken: counter-1, saturating at 0.
- FIFO:
  - Push when upd_valid && upd_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo QDEPTH.
  - flush does not affect the FIFO, because updates are committed state.

Optional Feature:
PREDICTOR_STAT_EN:
- When defined, adds input upd_pred_taken (1), plus outputs stat_branches (32) and stat_miss (32).
- On each FIFO push: stat_branches increments; stat_miss increments when upd_pred_taken != upd_taken.
- Both counters reset to 0 and wrap at 2^32.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Release reset with query_valid held: query_ready=0 for exactly 64 cycles (IDX_W=6), then 1. The first BRANCH query (inst 0x00000063, pc 0x100) returns pred_jump=0, target 0x104.
- In RUN, query JAL inst 0x0080006F at pc 0x200: next cycle pred_valid=1, pred_jump=1, target 0x208.
- Push 2 taken updates for pc 0x100 with no queries, then query BEQ at 0x100 with BImm=+16: pred_jump=1, target 0x110. Push 4 not-taken updates: counter saturates at 0 (check it does not wrap to 3).
- Hold query_valid every cycle and push 4 updates: upd_ready=0 once full. query_ready drops for one cycle, one drain occurs, then query_ready=1 again.
- Assert flush in the accept cycle: pred_valid=0 the next cycle. Assert rst with 3 updates queued: FIFO empties, the sweep restarts, and upd_ready=1.
- With PREDICTOR_STAT_EN: push 5 updates, 2 with mismatched upd_pred_taken → stat_branches=5, stat_miss=2.
